instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Writes the program into instruction memory for the pipeline controller to decode.
//  Collects bytes from the UART receiver and packs each group of 4 into a 32-bit
//  instruction word, first byte as the MSB.
//  Writes each word to instruction memory at consecutive word addresses from 0.
//  Stops after writing the HALT word, or flags overflow when memory runs out.
// PARAMETERS
//  NB_BYTE   8             width of one received byte
//  NB_INSTR  32            instruction word width (fixed at 4*NB_BYTE)
//  NB_ADDR   8             instruction memory word-address width (2**NB_ADDR words)
//  HALT_WORD 32'hFFFFFFFF  end-of-program marker; it is written to memory too
// PORTS
//  i_clk         in   1          system clock, rising edge
//  i_reset       in   1          asynchronous reset, active-high
//  i_start       in   1          one-cycle pulse that starts a load session
//  i_rx_data     in   NB_BYTE    received byte
//  i_rx_valid    in   1          one-cycle strobe: i_rx_data is valid
//  o_mem_wr_en   out  1          one-cycle instruction memory write strobe
//  o_mem_addr    out  NB_ADDR    word address for the write
//  o_mem_data    out  NB_INSTR   instruction word for the write
//  o_busy        out  1          a load session is in progress (RECV or WRITE)
//  o_done        out  1          HALT_WORD written; sticky until next i_start
//  o_overflow    out  1          memory full with no HALT; sticky until next i_start
//  o_word_count  out  NB_ADDR+1  words written this session, including HALT
// BEHAVIOUR
//  Reset (async, active-high):
//   - Every output and internal register goes to 0; state goes to IDLE.
//   - Reset mid-session discards any partially assembled word.
//  States: IDLE, RECV, WRITE, DONE, ERROR. All outputs are registered.
//  IDLE:
//   - i_rx_valid is ignored.
//   - On i_start, clear addr_ptr, byte_cnt, shift reg, o_word_count, o_done and
//     o_overflow, then go to RECV.
//  RECV:
//   - On i_rx_valid: shift <= {shift[NB_INSTR-NB_BYTE-1:0], i_rx_data}; byte_cnt++ (2 bits).
//   - If i_rx_valid arrives with byte_cnt==3, go to WRITE with the completed word latched.
//  WRITE (exactly 1 cycle):
//   - o_mem_wr_en=1, o_mem_addr=addr_ptr, o_mem_data=word.
//   - o_word_count increments in this same cycle.
//   - Next state, evaluated in this order:
//     - word==HALT_WORD: go to DONE and set o_done.
//     - addr_ptr=={NB_ADDR{1'b1}}: go to ERROR and set o_overflow.
//     - otherwise: addr_ptr++ and go to RECV.
//   - An i_rx_valid during WRITE is captured as byte 0 of the next word; no byte is lost.
//  Latency: 4th byte strobe in cycle N gives o_mem_wr_en high in cycle N+1, for 1 cycle.
//  o_mem_wr_en is 0 in every state except WRITE.
//   - o_mem_addr/o_mem_data hold their last written values when wr_en is 0.
//  o_busy is 1 in RECV and WRITE only.
//  DONE and ERROR:
//   - i_rx_valid is ignored.
//   - i_start begins a new session exactly as from IDLE.
//  i_start is ignored in RECV and WRITE.
//  i_start and i_rx_valid in the same IDLE cycle: start wins and the byte is dropped.
//  addr_ptr never wraps: a full memory always ends in ERROR, never in a write to address 0.
// TESTING
//  T1 reset:
//   - Assert i_reset mid-cycle -> all outputs 0 at once, without waiting for a clock edge.
//  T2 single word:
//   - i_start, then bytes 20,01,00,05 -> one wr_en pulse, addr 0, data 32'h20010005.
//   - o_word_count=1, o_busy=1.
//  T3 program with halt:
//   - Words 20010005, 00221820, FFFFFFFF -> writes at addr 0,1,2.
//   - Then o_done=1, o_busy=0, o_word_count=3.
//   - Extra bytes afterwards produce no write.
//  T4 overflow (NB_ADDR=2):
//   - 4 non-halt words -> writes at addr 0..3, then o_overflow=1, o_done=0.
//   - 5th word's bytes produce no write.
//  T5 reset mid-word:
//   - After bytes AA,BB, assert reset; then i_start and bytes 01,02,03,04.
//   - Required: addr 0 gets 32'h01020304.
//  T6 ignored inputs:
//   - Bytes in IDLE produce no write.
//   - i_start during RECV keeps byte_cnt and addr_ptr.
//   - Back-to-back byte strobes across WRITE assemble correctly (data 11223344 then 55667788).

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if
//   Bundles the byte-stream input side and the instruction-memory write side
//   of the loader.
//   master : the environment. It drives i_start, i_rx_data and i_rx_valid and
//            observes the memory write and status outputs.
//   slave  : the loader itself.
//   Signals:
//     i_start       one-cycle pulse that starts a load session
//     i_rx_data     received byte
//     i_rx_valid    one-cycle strobe that qualifies i_rx_data
//     o_mem_wr_en   one-cycle instruction memory write strobe
//     o_mem_addr    word address for the write
//     o_mem_data    instruction word for the write
//     o_busy        a load session is in progress
//     o_done        HALT word written (sticky)
//     o_overflow    memory full without HALT (sticky)
//     o_word_count  words written this session, including HALT
// -----------------------------------------------------------------------------
interface instr_mem_loader_if #(
  parameter int NB_BYTE  = 8,
  parameter int NB_INSTR = 32,
  parameter int NB_ADDR  = 8
);
  logic                i_start;
  logic [NB_BYTE-1:0]  i_rx_data;
  logic                i_rx_valid;
  logic                o_mem_wr_en;
  logic [NB_ADDR-1:0]  o_mem_addr;
  logic [NB_INSTR-1:0] o_mem_data;
  logic                o_busy;
  logic                o_done;
  logic                o_overflow;
  logic [NB_ADDR:0]    o_word_count;

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_mem_wr_en, o_mem_addr, o_mem_data,
    input  o_busy, o_done, o_overflow, o_word_count
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_mem_wr_en, o_mem_addr, o_mem_data,
    output o_busy, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader
//   Packs received bytes, four at a time and first byte as the MSB, into
//   instruction words. It writes each word to instruction memory at
//   consecutive word addresses starting from 0. A session ends in DONE after
//   the HALT word is written. If the last address is written without a HALT
//   word, the session ends in ERROR.
//   Ports:
//     i_clk    system clock, rising edge
//     i_reset  asynchronous reset, active-high
//     bus      instr_mem_loader_if.slave. It carries the byte stream, the
//              memory write and the status outputs. All outputs are
//              registered.
// -----------------------------------------------------------------------------
module instr_mem_loader #(
  parameter int                  NB_BYTE   = 8,
  parameter int                  NB_INSTR  = 4 * NB_BYTE,
  parameter int                  NB_ADDR   = 8,
  parameter logic [NB_INSTR-1:0] HALT_WORD = '1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  instr_mem_loader_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

  state_t              state_q,     state_d;
  logic [NB_ADDR-1:0]  addr_ptr_q,  addr_ptr_d;
  logic [1:0]          byte_cnt_q,  byte_cnt_d;
  logic [NB_INSTR-1:0] shift_q,     shift_d;
  logic                wr_en_q,     wr_en_d;
  logic [NB_ADDR-1:0]  mem_addr_q,  mem_addr_d;
  logic [NB_INSTR-1:0] mem_data_q,  mem_data_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                overflow_q,  overflow_d;
  logic [NB_ADDR:0]    word_cnt_q,  word_cnt_d;

  // The register holds every piece of state, so every output is a flop.
  // NOTE: sequential blocks use non-blocking (<=) assignments so that all
  // flops sample the pre-edge values of one another.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      addr_ptr_q <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      wr_en_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_ptr_q <= addr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      wr_en_q    <= wr_en_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    addr_ptr_d = addr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    word_cnt_d = word_cnt_q;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        // Bytes are ignored here. Start wins over a byte in the same cycle.
        if (bus.i_start) begin
          addr_ptr_d = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = RECV;
        end
      end

      RECV: begin
        if (bus.i_rx_valid) begin
          shift_d    = {shift_q[NB_INSTR-NB_BYTE-1:0], bus.i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          // On the fourth byte the write registers are loaded directly, so
          // the memory strobe appears one cycle after that byte.
          if (byte_cnt_q == 2'd3) begin
            mem_addr_d = addr_ptr_q;
            mem_data_d = shift_d;
            word_cnt_d = word_cnt_q + (NB_ADDR+1)'(1);
            state_d    = WRITE;
          end
        end
      end

      WRITE: begin
        // byte_cnt has wrapped to 0. A byte arriving now starts the next word.
        if (bus.i_rx_valid) begin
          shift_d    = {shift_q[NB_INSTR-NB_BYTE-1:0], bus.i_rx_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
        if (mem_data_q == HALT_WORD) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else if (addr_ptr_q == LAST_ADDR) begin
          // The pointer never wraps. A full memory ends the session here.
          overflow_d = 1'b1;
          state_d    = ERROR;
        end else begin
          addr_ptr_d = addr_ptr_q + NB_ADDR'(1);
          state_d    = RECV;
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobe and busy follow the next state, so they line up with it once
    // registered.
    wr_en_d = (state_d == WRITE);
    busy_d  = (state_d == RECV) || (state_d == WRITE);
  end

  assign bus.o_mem_wr_en  = wr_en_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_mem_data   = mem_data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_word_count = word_cnt_q;

endmodule
